// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Memory stage of the 5-stage pipeline. Passes non-memory instructions to
//   writeback with one cycle of latency. Loads and stores go out on a req/ack
//   data-memory port. While an access is outstanding the stage stalls upstream
//   and sends NOP bubbles to writeback. An access that gets no ack within
//   TIMEOUT_CYC wait cycles is dropped and raises a sticky error flag.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   valid3_in, ir3_in     EX-stage instruction and its valid flag
//   alu3_in, r1_3_in      ALU result / memory address, store data
//   mem_stall             combinational hold request to upstream stages
//   mem_req/we/addr/wdata registered data-memory request
//   mem_rdata, mem_ack    load data, one-cycle completion strobe
//   valid4_out, ir4_out   writeback instruction and its valid flag
//   IR4Wire_out           ir4_out[3:0], the opcode for writeback control
//   alu4_out, mdr4_out    ALU result and load data to writeback
//   mem_err               sticky timeout flag
//   state_dbg_out         FSM state (0 = IDLE, 1 = WAIT)
//
// Handshake: in WAIT, mem_req/mem_we/mem_addr/mem_wdata stay constant until
// the cycle in which mem_ack is sampled high. That cycle completes the access,
// and mem_req drops at the following edge. mem_ack is ignored in IDLE.
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int IR_W        = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid3_in,
  input  logic [IR_W-1:0]   ir3_in,
  input  logic [DATA_W-1:0] alu3_in,
  input  logic [DATA_W-1:0] r1_3_in,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              valid4_out,
  output logic [IR_W-1:0]   ir4_out,
  output logic [3:0]        IR4Wire_out,
  output logic [DATA_W-1:0] alu4_out,
  output logic [DATA_W-1:0] mdr4_out,
  output logic              mem_err,
  output logic              state_dbg_out
);

  localparam logic [IR_W-1:0] NOP   = {{(IR_W-4){1'b0}}, 4'b1010};
  localparam logic [3:0]      OP_LD = 4'b0000;
  localparam logic [3:0]      OP_ST = 4'b0010;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state, w_state_n;
  logic [IR_W-1:0]   r_ir_lat, w_ir_lat_n;
  logic [DATA_W-1:0] r_alu_lat, w_alu_lat_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic              r_req, w_req_n;
  logic              r_we, w_we_n;
  logic [DATA_W-1:0] r_addr, w_addr_n;
  logic [DATA_W-1:0] r_wdata, w_wdata_n;
  logic              r_valid4, w_valid4_n;
  logic [IR_W-1:0]   r_ir4, w_ir4_n;
  logic [DATA_W-1:0] r_alu4, w_alu4_n;
  logic [DATA_W-1:0] r_mdr4, w_mdr4_n;
  logic              r_err, w_err_n;
  logic              w_stall;
  logic              w_mem_op;

  assign w_mem_op = valid3_in && ((ir3_in[3:0] == OP_LD) || (ir3_in[3:0] == OP_ST));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ir_lat  <= '0;
      r_alu_lat <= '0;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_valid4  <= 1'b0;
      r_ir4     <= NOP;
      r_alu4    <= '0;
      r_mdr4    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_ir_lat  <= w_ir_lat_n;
      r_alu_lat <= w_alu_lat_n;
      r_cnt     <= w_cnt_n;
      r_req     <= w_req_n;
      r_we      <= w_we_n;
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
      r_valid4  <= w_valid4_n;
      r_ir4     <= w_ir4_n;
      r_alu4    <= w_alu4_n;
      r_mdr4    <= w_mdr4_n;
      r_err     <= w_err_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_ir_lat_n  = r_ir_lat;
    w_alu_lat_n = r_alu_lat;
    w_cnt_n     = r_cnt;
    w_req_n     = r_req;
    w_we_n      = r_we;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_valid4_n  = 1'b0;
    w_ir4_n     = NOP;
    w_alu4_n    = r_alu4;
    w_mdr4_n    = r_mdr4;
    w_err_n     = r_err;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          // Issue the access; this cycle is a bubble to writeback.
          w_stall     = 1'b1;
          w_ir_lat_n  = ir3_in;
          w_alu_lat_n = alu3_in;
          w_req_n     = 1'b1;
          w_we_n      = (ir3_in[3:0] == OP_ST);
          w_addr_n    = alu3_in;
          w_wdata_n   = r1_3_in;
          w_cnt_n     = '0;
          w_state_n   = S_WAIT;
        end else if (valid3_in) begin
          w_valid4_n = 1'b1;
          w_ir4_n    = ir3_in;
          w_alu4_n   = alu3_in;
        end
      end
      S_WAIT: begin
        // Ack is tested first so it beats a timeout in the same cycle.
        if (mem_ack) begin
          w_valid4_n = 1'b1;
          w_ir4_n    = r_ir_lat;
          w_alu4_n   = r_alu_lat;
          if (!r_we) w_mdr4_n = mem_rdata;
          w_req_n    = 1'b0;
          w_state_n  = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          // Give up: release upstream and drop the instruction.
          w_req_n   = 1'b0;
          w_err_n   = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_stall = 1'b1;
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign mem_stall     = w_stall;
  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign valid4_out    = r_valid4;
  assign ir4_out       = r_ir4;
  assign IR4Wire_out   = r_ir4[3:0];
  assign alu4_out      = r_alu4;
  assign mdr4_out      = r_mdr4;
  assign mem_err       = r_err;
  assign state_dbg_out = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed bench for mem_access_stage, built with TIMEOUT_CYC = 4. Each
//   stimulus step that should reach writeback pushes its expected
//   {ir4, alu4, mdr4} onto exp_q. A negedge monitor pops one entry for every
//   valid4_out and requires a NOP on every bubble.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int IR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [7:0] NOP = 8'h0A;

  logic              clock;
  logic              reset;
  logic              valid3_in;
  logic [IR_W-1:0]   ir3_in;
  logic [DATA_W-1:0] alu3_in;
  logic [DATA_W-1:0] r1_3_in;
  logic              mem_stall;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              valid4_out;
  logic [IR_W-1:0]   ir4_out;
  logic [3:0]        IR4Wire_out;
  logic [DATA_W-1:0] alu4_out;
  logic [DATA_W-1:0] mdr4_out;
  logic              mem_err;
  logic              state_dbg_out;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [23:0] exp_q[$];
  logic [7:0] model_mdr;

  mem_access_stage #(.IR_W(IR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .reset(reset), .valid3_in(valid3_in), .ir3_in(ir3_in),
    .alu3_in(alu3_in), .r1_3_in(r1_3_in), .mem_stall(mem_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valid4_out(valid4_out), .ir4_out(ir4_out), .IR4Wire_out(IR4Wire_out),
    .alu4_out(alu4_out), .mdr4_out(mdr4_out), .mem_err(mem_err),
    .state_dbg_out(state_dbg_out)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ir, input logic [7:0] alu,
                       input logic [7:0] r1);
    valid3_in = v;
    ir3_in    = ir;
    alu3_in   = alu;
    r1_3_in   = r1;
  endtask

  // scoreboard: writeback monitor
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (valid4_out) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL wb_unexpected observed=%0h expected=none", {ir4_out, alu4_out, mdr4_out});
        end
        if (exp_q.size() != 0) check("wb_data", {8'h0, ir4_out, alu4_out, mdr4_out}, {8'h0, exp_q.pop_front()});
      end else begin
        check("wb_bubble_nop", ir4_out, NOP);
      end
    end
  end

  initial begin
    int req_cnt;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    model_mdr = 8'h00;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    // 1: reset state
    check("rst_ir4wire", IR4Wire_out, 4'b1010);
    check("rst_valid4", valid4_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_err", mem_err, 0);
    check("rst_state", state_dbg_out, 0);
    mon_en = 1'b1;

    // 2: ORI passes through with one-cycle latency
    tick();
    drive(1'b1, 8'h37, 8'h5A, 8'h00);
    exp_q.push_back({8'h37, 8'h5A, model_mdr});
    #1 check("ori_stall", mem_stall, 0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    #1;
    check("ori_ir4", ir4_out, 8'h37);
    check("ori_alu4", alu4_out, 8'h5A);
    check("ori_valid4", valid4_out, 1);
    check("ori_stall2", mem_stall, 0);

    // 3: load, ack in 3rd WAIT cycle; load held upstream while stalled
    tick();
    drive(1'b1, 8'h00, 8'h10, 8'h00);
    model_mdr = 8'hC3;
    exp_q.push_back({8'h00, 8'h10, model_mdr});
    #1 check("ld_stall_c0", mem_stall, 1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 8'hC3; end
      #1;
      check("ld_stall", mem_stall, (c < 3) ? 1 : 0);
      check("ld_req", mem_req, 1);
      check("ld_addr", mem_addr, 8'h10);
      check("ld_we", mem_we, 0);
      check("ld_valid4_bubble", valid4_out, 0);
    end
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    #1;
    check("ld_req_drop", mem_req, 0);
    check("ld_ir4", ir4_out, 8'h00);
    check("ld_mdr4", mdr4_out, 8'hC3);
    check("ld_valid4", valid4_out, 1);

    // 4: store, ack in 1st WAIT cycle
    tick();
    drive(1'b1, 8'h02, 8'h20, 8'hAB);
    exp_q.push_back({8'h02, 8'h20, model_mdr});
    #1 check("st_stall_c0", mem_stall, 1);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h55;
    #1;
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 8'hAB);
    check("st_addr", mem_addr, 8'h20);
    check("st_stall_ack", mem_stall, 0);
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    #1;
    check("st_ir4wire", IR4Wire_out, 4'b0010);
    check("st_valid4", valid4_out, 1);
    check("st_mdr4_hold", mdr4_out, 8'hC3);

    // mem_ack in IDLE is ignored
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    #1;
    check("idle_ack_valid4", valid4_out, 0);
    check("idle_ack_req", mem_req, 0);
    check("idle_ack_mdr4", mdr4_out, 8'hC3);

    // 5: load with no ack times out after 4 WAIT cycles
    tick();
    drive(1'b1, 8'h00, 8'h30, 8'h00);
    #1 check("to_stall_c0", mem_stall, 1);
    tick();
    req_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 3) valid3_in = 1'b0;
      #1;
      check("to_stall", mem_stall, (i < 3) ? 1 : 0);
      if (mem_req) req_cnt++;
      tick();
    end
    check("to_req_cycles", req_cnt, 4);
    check("to_err", mem_err, 1);
    repeat (3) tick();
    check("to_err_sticky", mem_err, 1);

    // 6: reset in 2nd WAIT cycle abandons the access
    drive(1'b1, 8'h00, 8'h40, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    #1 check("rw_req_before", mem_req, 1);
    tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    model_mdr = 8'h00;
    #1;
    check("rw_req", mem_req, 0);
    check("rw_state", state_dbg_out, 0);
    check("rw_err_cleared", mem_err, 0);
    check("rw_valid4", valid4_out, 0);
    tick();
    drive(1'b1, 8'h45, 8'h77, 8'h00);
    exp_q.push_back({8'h45, 8'h77, model_mdr});
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    #1;
    check("rw_ori_ir4", ir4_out, 8'h45);
    check("rw_ori_alu4", alu4_out, 8'h77);
    check("rw_ori_valid4", valid4_out, 1);

    repeat (3) tick();
    check("sb_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
